// File: rtl/pipeline_stall_controller.sv
// Stall, flush and bubble control for an N-stage in-order pipeline.
// Back-propagates stall/flush demand, enforces a minimum stall hold, counts stall cycles and watches for deadlock.
module pipeline_stall_controller #(
    parameter int unsigned NUM_STAGES = 8,
    parameter int unsigned MIN_HOLD   = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_STAGES-1:0] stallReq_i,
    input  logic [NUM_STAGES-1:0] flushReq_i,
    input  logic                  clearStatus_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [CNT_W-1:0]      stallCycles_o,
    output logic                  deadlock_o
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [NUM_STAGES-1:0] w_demand;
    logic [NUM_STAGES-1:0] w_flush_mask;
    logic [NUM_STAGES-1:0] w_stall_nxt;
    logic [NUM_STAGES-1:0] w_flush_nxt;
    logic [NUM_STAGES-1:0] w_bubble_nxt;
    logic [HOLD_W-1:0]     w_hold_nxt [NUM_STAGES];

    logic [NUM_STAGES-1:0] r_stall;
    logic [NUM_STAGES-1:0] r_flush;
    logic [NUM_STAGES-1:0] r_bubble;
    logic [HOLD_W-1:0]     r_hold [NUM_STAGES];
    logic [CNT_W-1:0]      r_cnt;
    logic [WD_W-1:0]       r_wd;
    logic                  r_deadlock;

    // A request from stage j affects only the stages strictly in front of it.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_demand
        assign w_demand[i]     = |(stallReq_i >> (i + 1));
        assign w_flush_mask[i] = |(flushReq_i >> (i + 1));
    end

    always_comb begin
        w_stall_nxt  = '0;
        w_flush_nxt  = '0;
        w_bubble_nxt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_hold_nxt[i] = '0;
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_flush_nxt[i] = w_flush_mask[i];
            if (w_flush_mask[i]) begin
                w_stall_nxt[i] = 1'b0;
            end else if (r_stall[i] && (r_hold[i] != '0)) begin
                w_stall_nxt[i] = 1'b1;
                w_hold_nxt[i]  = r_hold[i] - HOLD_W'(1);
            end else begin
                w_stall_nxt[i] = w_demand[i];
                if (w_demand[i] && !r_stall[i]) begin
                    w_hold_nxt[i] = HOLD_W'(MIN_HOLD - 1);
                end
            end
        end
        // Stage i receives a NOP when the stage ahead holds but stage i itself moves on.
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_bubble_nxt[i] = w_stall_nxt[i-1] & ~w_stall_nxt[i] & ~w_flush_nxt[i];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall  <= '0;
            r_flush  <= '0;
            r_bubble <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_stall  <= w_stall_nxt;
            r_flush  <= w_flush_nxt;
            r_bubble <= w_bubble_nxt;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
        end
    end

    // Saturating stall-cycle counter and consecutive-stall watchdog on stage 0.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt      <= '0;
            r_wd       <= '0;
            r_deadlock <= 1'b0;
        end else if (clearStatus_i) begin
            r_cnt      <= '0;
            r_wd       <= '0;
            r_deadlock <= 1'b0;
        end else begin
            if (r_stall[0] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_stall[0] && (r_wd == WD_W'(TIMEOUT - 1))) begin
                r_deadlock <= 1'b1;
            end
            if (!r_stall[0] || w_flush_mask[0]) begin
                r_wd <= '0;
            end else if (r_wd != WD_W'(TIMEOUT - 1)) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

    assign stall_o       = r_stall;
    assign flush_o       = r_flush;
    assign bubble_o      = r_bubble;
    assign stallCycles_o = r_cnt;
    assign deadlock_o    = r_deadlock;

endmodule
